// File: rtl/stop_it_ctrl_if.sv
// Control/datapath signal bundle for stop_it_ctrl. The slave modport is the controller's view.
interface stop_it_ctrl_if;
    logic       go_i;
    logic       stop_i;
    logic       load_i;
    logic [4:0] load_value_i;
    logic       match_i;
    logic [2:0] state_o;
    logic       target_load_o;
    logic       count_en_o;
    logic [4:0] score_o;
    logic       flash_o;
    logic       won_o;

    modport slave (
        input  go_i, stop_i, load_i, load_value_i, match_i,
        output state_o, target_load_o, count_en_o, score_o, flash_o, won_o
    );

    modport master (
        output go_i, stop_i, load_i, load_value_i, match_i,
        input  state_o, target_load_o, count_en_o, score_o, flash_o, won_o
    );
endinterface

// File: rtl/stop_it_ctrl.sv
// stop_it_ctrl: round sequencer for the stop_it game; owns the pause timer and win score.
// Define STOP_IT_CTRL_TIMEOUT_EN to force WRONG when no stop arrives within TIMEOUT_CYCLES.
module stop_it_ctrl #(
    parameter int WINS_TO_WIN         = 17,
    parameter int START_PAUSE_CYCLES  = 8,
    parameter int RESULT_PAUSE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES      = 128
) (
    input  logic          clk_4_i,
    input  logic          rst_i,
    stop_it_ctrl_if.slave bus
);
    localparam int PAUSE_MAX = (START_PAUSE_CYCLES > RESULT_PAUSE_CYCLES) ?
                               START_PAUSE_CYCLES : RESULT_PAUSE_CYCLES;
    localparam int TIMER_W = $clog2(PAUSE_MAX + 1);
    localparam logic [TIMER_W-1:0] START_LAST  = TIMER_W'(START_PAUSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_PAUSE_CYCLES - 1);
    localparam logic [4:0] SCORE_CAP = 5'(WINS_TO_WIN - 1);
    localparam logic [4:0] SCORE_WIN = 5'(WINS_TO_WIN);

    if (WINS_TO_WIN < 1 || WINS_TO_WIN > 31) begin : g_bad_wins
        $error("stop_it_ctrl: WINS_TO_WIN must lie in 1..31");
    end
    if (START_PAUSE_CYCLES < 1 || RESULT_PAUSE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("stop_it_ctrl: pause and timeout lengths must be at least 1");
    end

    typedef enum logic [2:0] {
        S_WAITING    = 3'd0,
        S_STARTING   = 3'd1,
        S_DECREMENT  = 3'd2,
        S_CORRECT    = 3'd3,
        S_WRONG      = 3'd4,
        S_WON        = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [4:0]           score_q, score_d;
    logic                 timed_out;

`ifdef STOP_IT_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Held at zero outside DECREMENTING, so every entry starts a fresh window.
    assign to_cnt_d  = (state_q == S_DECREMENT) ? to_cnt_q + TO_W'(1) : '0;
    assign timed_out = (state_q == S_DECREMENT) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk_4_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk_4_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_WAITING;
            timer_q <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            score_q <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TIMER_W'(1);
        score_d = score_q;
        unique case (state_q)
            S_WAITING: begin
                timer_d = '0;
                if (bus.load_i) begin
                    score_d = (bus.load_value_i > SCORE_CAP) ? SCORE_CAP : bus.load_value_i;
                end else if (bus.go_i) begin
                    state_d = S_STARTING;
                end
            end
            S_STARTING: begin
                if (timer_q == START_LAST) begin
                    state_d = S_DECREMENT;
                    timer_d = '0;
                end
            end
            S_DECREMENT: begin
                timer_d = '0;
                if (bus.stop_i) begin
                    state_d = bus.match_i ? S_CORRECT : S_WRONG;
                    if (bus.match_i) begin
                        score_d = score_q + 5'd1;
                    end
                end else if (timed_out) begin
                    state_d = S_WRONG;
                end
            end
            S_CORRECT: begin
                if (timer_q == RESULT_LAST) begin
                    state_d = (score_q == SCORE_WIN) ? S_WON : S_WAITING;
                    timer_d = '0;
                end
            end
            S_WRONG: begin
                if (timer_q == RESULT_LAST) begin
                    state_d = S_WAITING;
                    timer_d = '0;
                end
            end
            S_WON: begin
                // Timer free-runs here purely to drive the flash pattern.
            end
            default: begin
                state_d = S_WAITING;
                timer_d = '0;
            end
        endcase
    end

    logic target_load, count_en, flash, won;

    always_comb begin
        target_load = 1'b0;
        count_en    = 1'b0;
        flash       = 1'b0;
        won         = 1'b0;
        case (state_q)
            S_STARTING:  target_load = (timer_q == '0);
            S_DECREMENT: count_en    = 1'b1;
            S_CORRECT:   flash       = timer_q[0];
            S_WRONG:     flash       = 1'b1;
            S_WON: begin
                flash = timer_q[0];
                won   = 1'b1;
            end
            default: begin
                target_load = 1'b0;
            end
        endcase
    end

    assign bus.state_o       = state_q;
    assign bus.target_load_o = target_load;
    assign bus.count_en_o    = count_en;
    assign bus.score_o       = score_q;
    assign bus.flash_o       = flash;
    assign bus.won_o         = won;
endmodule
